instr_loader: RTL and testbench

Serial boot loader that fills the instruction cache array over a byte stream (from the UART receiver) while holding the core in reset. It parses a framed image (sync, length, little-endian words, XOR checksum) and emits one word write per received instruction. It reports completion or failure. It is the write-side counterpart to the read-only `instr_cache` fetch port and sits between the UART RX block and the cache array's write port.

---
 rtl/instr_loader_if.sv | 25 ++
 rtl/instr_loader.sv | 121 ++++++++++++
 tb/tb_instr_loader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream and cache-write signals of the serial instruction loader.
// The loader attaches through the slave modport; the UART/cache side uses master.
interface instr_loader_if;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        wr_en_o;
    logic [28:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        error_o;

    modport slave (
        input  byte_valid_i, byte_i,
        output byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
               cpu_hold_o, done_o, error_o
    );

    modport master (
        output byte_valid_i, byte_i,
        input  byte_ready_o, wr_en_o, wr_addr_o, wr_data_o,
               cpu_hold_o, done_o, error_o
    );
endinterface

// File: rtl/instr_loader.sv
// Serial boot loader: parses sync/length/words/XOR-checksum frames from a byte
// stream and writes each word into the instruction array while holding the core.
module instr_loader #(
    parameter int unsigned DEPTH       = 8192,
    parameter logic [28:0] BASE_ADDR   = '0,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input logic            clk_i,
    input logic            rst_ni,
    instr_loader_if.slave  bus
);
    localparam int          CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_e;

    state_e             state_q, state_d;
    logic [7:0]         acc_q;
    logic [15:0]        len_q;
    logic [15:0]        word_idx_q;
    logic [1:0]         byte_sel_q;
    logic [23:0]        asm_q;
    logic [CNT_W-1:0]   tmo_q;

    logic        accept;
    logic        in_frame;
    logic        timeout;
    logic        start;
    logic        wr_fire;
    logic [15:0] len_full;

    // The loader never back-pressures the receiver.
    assign bus.byte_ready_o = 1'b1;
    assign accept   = bus.byte_valid_i;
    assign len_full = {bus.byte_i, len_q[7:0]};
    assign in_frame = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                      (state_q == DATA)   || (state_q == CSUM);
    assign timeout  = in_frame && !accept && (tmo_q == CNT_W'(TIMEOUT_CYC - 1));

    // NOTE: every combinational output gets a default first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        wr_fire = 1'b0;
        unique case (state_q)
            IDLE, DONE, ERR: if (accept && bus.byte_i == SYNC_BYTE) begin
                state_d = LEN_LO;
                start   = 1'b1;
            end
            LEN_LO: if (accept) state_d = LEN_HI;
            LEN_HI: if (accept) begin
                if ({1'b0, len_full} > DEPTH_L) state_d = ERR;
                else if (len_full == 16'd0)     state_d = CSUM;
                else                            state_d = DATA;
            end
            DATA: if (accept && byte_sel_q == 2'd3) begin
                wr_fire = 1'b1;
                if (word_idx_q == len_q - 16'd1) state_d = CSUM;
            end
            CSUM: if (accept) state_d = (bus.byte_i == acc_q) ? DONE : ERR;
            default: state_d = IDLE;
        endcase
        // A stalled frame aborts; any half-built word is simply never written.
        if (timeout) begin
            state_d = ERR;
            wr_fire = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            len_q          <= '0;
            word_idx_q     <= '0;
            byte_sel_q     <= '0;
            asm_q          <= '0;
            tmo_q          <= '0;
            bus.wr_en_o    <= 1'b0;
            bus.wr_addr_o  <= '0;
            bus.wr_data_o  <= '0;
            bus.cpu_hold_o <= 1'b1;
            bus.done_o     <= 1'b0;
            bus.error_o    <= 1'b0;
        end else begin
            state_q <= state_d;

            // Status flags are registered straight from the next state.
            bus.done_o     <= (state_d == DONE);
            bus.error_o    <= (state_d == ERR);
            bus.cpu_hold_o <= (state_d != DONE);
            bus.wr_en_o    <= wr_fire;

            if (!in_frame || accept) tmo_q <= '0;
            else                     tmo_q <= tmo_q + CNT_W'(1);

            if (start) begin
                acc_q      <= '0;
                word_idx_q <= '0;
                byte_sel_q <= '0;
            end else if (accept) begin
                if (state_q == LEN_LO || state_q == LEN_HI || state_q == DATA)
                    acc_q <= acc_q ^ bus.byte_i;
                if (state_q == LEN_LO) len_q[7:0]  <= bus.byte_i;
                if (state_q == LEN_HI) len_q[15:8] <= bus.byte_i;
                if (state_q == DATA) begin
                    byte_sel_q <= byte_sel_q + 2'd1;
                    if (byte_sel_q != 2'd3) asm_q[8*byte_sel_q +: 8] <= bus.byte_i;
                end
            end

            if (wr_fire) begin
                bus.wr_addr_o <= BASE_ADDR + 29'(word_idx_q);
                bus.wr_data_o <= {bus.byte_i, asm_q};
                word_idx_q    <= word_idx_q + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: directed frames push expected writes, a
// negedge monitor pops and compares each write strobe it observes.
module tb_instr_loader;
    localparam int TMO = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    instr_loader_if bus();

    instr_loader #(
        .DEPTH(8192), .BASE_ADDR(29'd0), .TIMEOUT_CYC(TMO), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [28:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_errors = 0;

    logic [7:0] good_frame[12] = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00,
                                    8'h00, 8'h13, 8'h01, 8'h00, 8'h10, 8'h93};
    int         gaps[12]       = '{1, 50, 3, 7, 0, 20, 2, 1, 13, 5, 9, 4};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.wr_en_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         bus.wr_addr_o, bus.wr_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr_o), 32'(mon_e.addr));
                check("wr_data", bus.wr_data_o, mon_e.data);
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        bus.byte_valid_i = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        bus.byte_valid_i = 1'b1;
        bus.byte_i       = b;
        @(posedge clk);
        #1;
        bus.byte_valid_i = 1'b0;
    endtask

    task automatic status(input string tag, input logic d, input logic e, input logic h);
        check({tag, "_done"},  32'(bus.done_o),     32'(d));
        check({tag, "_error"}, 32'(bus.error_o),    32'(e));
        check({tag, "_hold"},  32'(bus.cpu_hold_o), 32'(h));
    endtask

    task automatic push_good_writes();
        exp_q.push_back('{addr: 29'd0, data: 32'h0000_0093});
        exp_q.push_back('{addr: 29'd1, data: 32'h1000_0113});
    endtask

    // Sends the good frame with an optional checksum override and optional gaps.
    task automatic send_good(input logic [7:0] csum, input bit use_gaps);
        for (int i = 0; i < 12; i++)
            send((i == 11) ? csum : good_frame[i], use_gaps ? gaps[i] : 0);
    endtask

    task automatic wait_timeout(input string tag);
        int cyc = 0;
        while (!bus.error_o && cyc < 3 * TMO) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_timeout_cycles"}, 32'(cyc), 32'(TMO));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.byte_valid_i = 1'b0;
        bus.byte_i       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        status("reset", 1'b0, 1'b0, 1'b1);
        check("reset_wr_en", 32'(bus.wr_en_o), 32'd0);
        check("reset_ready", 32'(bus.byte_ready_o), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Good frame, back-to-back.
        push_good_writes();
        send_good(8'h93, 1'b0);
        status("good", 1'b1, 1'b0, 1'b0);
        check("good_writes_drained", 32'(exp_q.size()), 32'd0);

        // Wrong checksum: writes still land, error flagged.
        push_good_writes();
        send_good(8'h94, 1'b0);
        status("badcsum", 1'b0, 1'b1, 1'b1);
        check("badcsum_writes_drained", 32'(exp_q.size()), 32'd0);

        // N = 8193 exceeds the array: error right after the length.
        send(8'hA5, 0); send(8'h01, 0); send(8'h20, 0);
        status("len8193", 1'b0, 1'b1, 1'b1);

        // N = 8192 is legal: the loader waits for data, then times out.
        send(8'hA5, 0); send(8'h00, 0); send(8'h20, 0);
        status("len8192", 1'b0, 1'b0, 1'b1);
        wait_timeout("len8192");

        // N = 0 with checksum 0.
        send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        status("len0", 1'b1, 1'b0, 1'b0);

        // Stall inside a word: partial word discarded, error after exactly TMO cycles.
        send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h93, 0); send(8'h00, 0);
        check("tmo_no_error_yet", 32'(bus.error_o), 32'd0);
        wait_timeout("partial");
        status("partial", 1'b0, 1'b1, 1'b1);

        push_good_writes();
        send_good(8'h93, 1'b0);
        status("after_tmo", 1'b1, 1'b0, 1'b0);

        // Noise while done is ignored.
        send(8'h00, 0); send(8'hFF, 2); send(8'h13, 0);
        status("noise", 1'b1, 1'b0, 1'b0);

        // Same frame with gaps on the valid strobe.
        push_good_writes();
        send_good(8'h93, 1'b1);
        status("gaps", 1'b1, 1'b0, 1'b0);
        check("gaps_writes_drained", 32'(exp_q.size()), 32'd0);

        // Re-sync from DONE raises hold next cycle; then reset mid-DATA.
        send(8'hA5, 0);
        status("resync", 1'b0, 1'b0, 1'b1);
        send(8'h02, 0); send(8'h00, 0); send(8'h93, 0); send(8'h00, 0);
        rst_n = 1'b0;
        #1;
        status("midreset", 1'b0, 1'b0, 1'b1);
        check("midreset_addr", 32'(bus.wr_addr_o), 32'd0);
        check("midreset_data", bus.wr_data_o, 32'd0);
        check("midreset_wr_en", 32'(bus.wr_en_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 5; i < 12; i++) send(good_frame[i], 0);
        repeat (5) @(posedge clk);
        #1;
        status("post_reset", 1'b0, 1'b0, 1'b1);
        check("post_reset_queue", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
